bb84_sift_engine: RTL

Clocked, parametrised BB84 key-exchange engine. It replaces the single-shot combinational Alice/Bob/spy link with a frame-based session. One frame of KEY_W raw qubits is transmitted one per cycle through an optional intercept-resend eavesdropper. The engine sifts on basis agreement, spends the first CHECK_N sifted bits on error estimation, and delivers the remaining key with an abort flag. It sits between the key-material source (Alice/Bob basis generators) and downstream privacy-amplification logic.

---
 rtl/bb84_pkg.sv | 27 ++
 rtl/bb84_lfsr.sv | 30 +++
 rtl/bb84_sift_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bb84_pkg.sv
// bb84_pkg
// Shared types and constants for the BB84 sift engine.
//   state_t     : engine FSM states
//   BASIS_*     : basis encoding carried on the channel
//   qubit_t     : channel symbol layout {bit, basis}
//   LFSR_*      : width and Fibonacci tap mask (taps 16,14,13,11)
package bb84_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic BASIS_RECT = 1'b0;
    localparam logic BASIS_DIAG = 1'b1;

    typedef struct packed {
        logic data;
        logic basis;
    } qubit_t;

    localparam int          LFSR_W    = 16;
    // Bit k-1 set means tap k participates in the feedback XOR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/bb84_lfsr.sv
// bb84_lfsr
// Fibonacci LFSR shifting toward the MSB, feedback enters at bit 0.
//   clk, rst : clock, synchronous active-high reset (loads SEED)
//   adv      : advance one step this cycle
//   low      : lowest OUT_W bits of the current state
module bb84_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter logic [WIDTH-1:0] TAPS  = {1'b1, {(WIDTH-1){1'b0}}},
    parameter int               OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [OUT_W-1:0] low
);

    logic [WIDTH-1:0] state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (adv) begin
            state <= {state[WIDTH-2:0], ^(state & TAPS)};
        end
    end

    assign low = state[OUT_W-1:0];

endmodule

// File: rtl/bb84_sift_engine.sv
// bb84_sift_engine
// Frame-based BB84 exchange: one raw qubit per cycle through an optional
// intercept-resend eavesdropper, basis sifting, error estimation on the
// first CHECK_N sifted bits, remaining bits delivered as key.
//   clk, rst                          : clock, synchronous active-high reset
//   start                             : begin frame (IDLE only)
//   alice_bits/alice_basis/bob_basis  : per-qubit frame data, latched at start
//   spy_en                            : eavesdropper enable, latched at start
//   busy, done                        : frame in progress / end-of-frame pulse
//   qubit, bob_bit                    : channel symbol and Bob's measurement
//   sifted_key, sifted_len, err_cnt   : frame results, held until next start
//   abort                             : session rejected, valid with done
//
// state   | meaning
// IDLE    | results held, waiting for start
// XMIT    | one qubit per cycle, idx 0..KEY_W-1
// DONE    | done pulse, abort decision
module bb84_sift_engine
    import bb84_pkg::*;
#(
    parameter int          KEY_W     = 16,
    parameter int          CHECK_N   = 4,
    parameter int          ERR_MAX   = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         CW        = $clog2(KEY_W + 1),
    localparam int         IW        = $clog2(KEY_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] alice_bits,
    input  logic [KEY_W-1:0] alice_basis,
    input  logic [KEY_W-1:0] bob_basis,
    input  logic             spy_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       qubit,
    output logic             bob_bit,
    output logic [KEY_W-1:0] sifted_key,
    output logic [CW-1:0]    sifted_len,
    output logic [CW-1:0]    err_cnt,
    output logic             abort
);

    state_t           state, state_nx;
    logic [IW-1:0]    idx;
    logic [KEY_W-1:0] bits_q, abasis_q, bbasis_q;
    logic             spy_q;
    logic [CW-1:0]    chk_cnt;
    logic [2:0]       rnd;
    logic             adv;

    qubit_t           ch;
    logic             a_bit, a_basis, b_basis;
    logic             meas, sift, chk_phase;

    bb84_lfsr #(
        .WIDTH (LFSR_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS),
        .OUT_W (3)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (adv),
        .low (rnd)
    );

    // The LFSR only moves while qubits are on the channel, so consecutive
    // frames draw from one continuous random stream.
    assign adv = (state == ST_XMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_XMIT;
            ST_XMIT: if (idx == IW'(KEY_W - 1)) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Channel and measurement for the current index. Eve measures in basis
    // rnd[0]; on a basis miss she resends a random bit rnd[1] in her basis.
    // Bob gets a random outcome rnd[2] whenever his basis misses the channel.
    always_comb begin
        a_bit    = bits_q[idx];
        a_basis  = abasis_q[idx];
        b_basis  = bbasis_q[idx];
        ch.data  = a_bit;
        ch.basis = a_basis;
        if (spy_q && (rnd[0] != a_basis)) begin
            ch.data  = rnd[1];
            ch.basis = rnd[0];
        end
        meas      = (b_basis == ch.basis) ? ch.data : rnd[2];
        sift      = (b_basis == a_basis);
        chk_phase = int'(chk_cnt) < CHECK_N;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            bits_q     <= '0;
            abasis_q   <= '0;
            bbasis_q   <= '0;
            spy_q      <= 1'b0;
            chk_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            qubit      <= {1'b0, BASIS_RECT};
            bob_bit    <= 1'b0;
            sifted_key <= '0;
            sifted_len <= '0;
            err_cnt    <= '0;
            abort      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bits_q     <= alice_bits;
                        abasis_q   <= alice_basis;
                        bbasis_q   <= bob_basis;
                        spy_q      <= spy_en;
                        idx        <= '0;
                        chk_cnt    <= '0;
                        sifted_key <= '0;
                        sifted_len <= '0;
                        err_cnt    <= '0;
                        abort      <= 1'b0;
                    end
                end
                ST_XMIT: begin
                    busy    <= 1'b1;
                    qubit   <= ch;
                    bob_bit <= meas;
                    idx     <= idx + 1'b1;
                    if (sift) begin
                        if (chk_phase) begin
                            chk_cnt <= chk_cnt + 1'b1;
                            if (meas != a_bit) err_cnt <= err_cnt + 1'b1;
                        end else begin
                            sifted_key <= sifted_key | (KEY_W'(meas) << sifted_len);
                            sifted_len <= sifted_len + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    abort <= (int'(err_cnt) > ERR_MAX) || chk_phase;
                end
                default: ;
            endcase
        end
    end

endmodule
